instruction_prefetch: RTL and testbench
=======================================

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 The module SHALL have parameter PROGRAM_ADDR_WIDTH, default 16, width of the program memory byte address and PC.
REQ-002 The module SHALL have parameter FIFO_DEPTH_MAG, default 2, log2 of the byte buffer depth (DEPTH = 1 << FIFO_DEPTH_MAG).
REQ-003 Port clk: input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset: input, 1, asynchronous active-low reset.
REQ-005 Port programmem_addr: output, PROGRAM_ADDR_WIDTH, read address to program memory.
REQ-006 Port programmem_read_value: input, 8, program memory data, valid exactly one cycle after its address.
REQ-007 Port jump: input, 1, core requests redirect of the instruction stream.
REQ-008 Port jump_addr: input, PROGRAM_ADDR_WIDTH, redirect target, sampled only when jump=1.
REQ-009 Port consume: input, 1, core takes the head byte this cycle.
REQ-010 Port instr_valid: output, 1, head byte present.
REQ-011 Port instr_byte: output, 8, head instruction byte.
REQ-012 Port instr_pc: output, PROGRAM_ADDR_WIDTH, program address of instr_byte.

Function
REQ-013 State: fetch_addr (PROGRAM_ADDR_WIDTH), FIFO of DEPTH entries {byte, pc}, occupancy count (0..DEPTH), one in-flight flag with its address.
REQ-014 Issue condition: jump=1, or count + inflight < DEPTH (no credit taken for a same-cycle pop).
REQ-015 On issue without jump: programmem_addr = fetch_addr; fetch_addr <= fetch_addr + 1; inflight <= 1 with that address.
REQ-016 When not issuing: programmem_addr = fetch_addr (don't-care to memory); inflight <= 0.
REQ-017 Cycle after an issue: programmem_read_value and its recorded address written to the FIFO tail; count increments.
REQ-018 instr_valid = (count != 0); instr_byte/instr_pc = FIFO head, combinational from state.
REQ-019 consume with instr_valid=1 pops the head; consume with instr_valid=0 is ignored (no underflow, no state change).
REQ-020 Simultaneous write and pop: count unchanged, both applied.
REQ-021 Jump in cycle N: FIFO flushed (count <= 0), in-flight response arriving in N discarded, consume in N ignored.
REQ-022 Jump in cycle N: programmem_addr = jump_addr combinationally; fetch_addr <= jump_addr + 1; inflight <= 1 with jump_addr.
REQ-023 Jump latency: byte at jump_addr written end of N+1, instr_valid=1 in N+2 with instr_pc = jump_addr.
REQ-024 Back-to-back jumps: the last one wins; earlier targets never appear at the output.
REQ-025 fetch_addr wraps modulo 2^PROGRAM_ADDR_WIDTH (all-ones -> 0) with no special handling.
REQ-026 Sustained consume every cycle with instr_valid=1 SHALL yield one byte per cycle, no bubbles, in order.
REQ-027 FIFO full (count=DEPTH, inflight=0): no issue, fetch_addr holds until a pop.
REQ-028 Bytes reach the output strictly in address order since the last jump or reset.

Reset
REQ-029 reset=0 asynchronously clears: fetch_addr=0, count=0, inflight=0, FIFO pointers=0; instr_valid=0 immediately.
REQ-030 During reset programmem_addr = 0; FIFO data contents are don't-care.
REQ-031 First cycle after release issues address 0; instr_valid=1 with instr_pc=0 two cycles later.
REQ-032 Reset asserted mid-stream discards all buffered and in-flight bytes; no pre-reset byte appears after release.

Verification
REQ-033 Reset release, memory[a]=a[7:0], consume=0 -> instr_pc 0,1,2,3 buffered (DEPTH 4), issue stops, programmem_addr holds 4.
REQ-034 Consume held 1 from release -> instr_byte 0x00,0x01,0x02,... one per cycle from cycle 2, no gaps.
REQ-035 Full FIFO, jump=1 jump_addr=0x1234 -> instr_valid 0 in N+1, instr_pc=0x1234 in N+2, then 0x1235.
REQ-036 jump_addr=0xFFFF (width 16), consume=1 -> instr_pc 0xFFFF then 0x0000 on consecutive cycles.
REQ-037 consume=1 while empty, and consume=1 same cycle as jump -> ignored, no duplicate or lost byte.
REQ-038 reset pulsed low for a half cycle mid-stream -> instr_valid 0 at once, restart from address 0.

Source files
------------

// File: rtl/instruction_prefetch.sv
// Instruction prefetcher: streams program bytes from a one-cycle-latency memory
// into a small byte FIFO, tagging each byte with its program address.
module instruction_prefetch #(
  parameter int PROGRAM_ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH_MAG     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [PROGRAM_ADDR_WIDTH-1:0] programmem_addr,
  input  logic [7:0]                    programmem_read_value,
  input  logic                          jump,
  input  logic [PROGRAM_ADDR_WIDTH-1:0] jump_addr,
  input  logic                          consume,
  output logic                          instr_valid,
  output logic [7:0]                    instr_byte,
  output logic [PROGRAM_ADDR_WIDTH-1:0] instr_pc
);

  localparam int DEPTH = 1 << FIFO_DEPTH_MAG;
  localparam int CW    = FIFO_DEPTH_MAG + 1;
  localparam int OW    = FIFO_DEPTH_MAG + 2;

  logic [PROGRAM_ADDR_WIDTH-1:0] fetch_addr;
  logic [PROGRAM_ADDR_WIDTH-1:0] inflight_addr;
  logic                          inflight;
  logic [CW-1:0]                 count;
  logic [FIFO_DEPTH_MAG-1:0]     wr_ptr;
  logic [FIFO_DEPTH_MAG-1:0]     rd_ptr;

  logic [7:0]                    byte_mem [DEPTH];
  logic [PROGRAM_ADDR_WIDTH-1:0] pc_mem   [DEPTH];

  logic issue;
  logic fifo_write;
  logic fifo_pop;

  // Credit check counts the outstanding read so the FIFO can never overflow;
  // a pop in the same cycle is deliberately not credited.
  assign issue      = jump || (({1'b0, count} + OW'(inflight)) < OW'(DEPTH));
  assign fifo_write = inflight && !jump;
  assign fifo_pop   = consume && (count != '0) && !jump;

  assign programmem_addr = !reset ? '0 : (jump ? jump_addr : fetch_addr);

  assign instr_valid = (count != '0);
  assign instr_byte  = byte_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_addr    <= '0;
      inflight_addr <= '0;
      inflight      <= 1'b0;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else if (jump) begin
      // Redirect: drop buffered bytes and the response now arriving.
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      inflight      <= 1'b1;
      inflight_addr <= jump_addr;
      fetch_addr    <= jump_addr + PROGRAM_ADDR_WIDTH'(1);
    end else begin
      if (fifo_write) wr_ptr <= wr_ptr + FIFO_DEPTH_MAG'(1);
      if (fifo_pop)   rd_ptr <= rd_ptr + FIFO_DEPTH_MAG'(1);
      case ({fifo_write, fifo_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (issue) begin
        inflight      <= 1'b1;
        inflight_addr <= fetch_addr;
        fetch_addr    <= fetch_addr + PROGRAM_ADDR_WIDTH'(1);
      end else begin
        inflight      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_write) begin
      byte_mem[wr_ptr] <= programmem_read_value;
      pc_mem[wr_ptr]   <= inflight_addr;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Randomized bench for instruction_prefetch against a queue-based model of the
// expected byte stream and memory address sequence.
module tb_instruction_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] programmem_addr;
  logic [7:0]  programmem_read_value = 8'h00;
  logic        jump = 1'b0;
  logic [15:0] jump_addr = 16'h0000;
  logic        consume = 1'b0;
  logic        instr_valid;
  logic [7:0]  instr_byte;
  logic [15:0] instr_pc;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  bit          pend;
  logic [15:0] pend_addr;
  logic [15:0] next_addr;

  instruction_prefetch #(.PROGRAM_ADDR_WIDTH(16), .FIFO_DEPTH_MAG(2)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .programmem_addr       (programmem_addr),
    .programmem_read_value (programmem_read_value),
    .jump                  (jump),
    .jump_addr             (jump_addr),
    .consume               (consume),
    .instr_valid           (instr_valid),
    .instr_byte            (instr_byte),
    .instr_pc              (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // Program memory with one cycle of read latency.
  always @(posedge clk) programmem_read_value <= mem_fn(programmem_addr);

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend      = 1'b0;
    pend_addr = 16'h0000;
    next_addr = 16'h0000;
  endtask

  // Expected effect of one rising edge, given the inputs driven during the cycle.
  task automatic model_step();
    int sz;
    bit iss;
    sz  = exp_q.size();
    iss = jump || ((sz + int'(pend)) < DEPTH);
    if (jump) begin
      exp_q.delete();
      pend      = 1'b1;
      pend_addr = jump_addr;
      next_addr = jump_addr + 16'd1;
    end else begin
      if (consume && sz > 0) void'(exp_q.pop_front());
      if (pend) exp_q.push_back(pend_addr);
      if (iss) begin
        pend      = 1'b1;
        pend_addr = next_addr;
        next_addr = next_addr + 16'd1;
      end else begin
        pend = 1'b0;
      end
    end
  endtask

  task automatic check_state();
    check_output("valid", 32'(instr_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_output("pc", 32'(instr_pc), 32'(exp_q[0]));
      check_output("byte", 32'(instr_byte), 32'(mem_fn(exp_q[0])));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply_stimulus(input bit j, input logic [15:0] ja, input bit c);
    check_state();
    jump      = j;
    jump_addr = ja;
    consume   = c;
    #1;
    check_output("addr", 32'(programmem_addr), 32'(j ? ja : next_addr));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    jump    = 1'b0;
    consume = 1'b0;
    reset   = 1'b0;
    #1;
    check_output("rst_valid", 32'(instr_valid), 32'd0);
    check_output("rst_addr", 32'(programmem_addr), 32'd0);
    model_clear();
    #2;
    reset = 1'b1;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    check_output("init_valid", 32'(instr_valid), 32'd0);
    check_output("init_addr", 32'(programmem_addr), 32'd0);
    reset = 1'b1;

    // Fill with no consumption: four bytes buffered, fetch parks at 4.
    repeat (8) apply_stimulus(1'b0, 16'h0, 1'b0);
    check_output("fill_count", 32'(exp_q.size()), 32'(DEPTH));
    check_output("park_addr", 32'(programmem_addr), 32'h4);

    // Sustained consumption.
    repeat (12) apply_stimulus(1'b0, 16'h0, 1'b1);

    // Fill, then redirect while full.
    repeat (6) apply_stimulus(1'b0, 16'h0, 1'b0);
    apply_stimulus(1'b1, 16'h1234, 1'b1);
    check_output("jmp_n1_valid", 32'(instr_valid), 32'd0);
    apply_stimulus(1'b0, 16'h0, 1'b1);
    check_output("jmp_n2_pc", 32'(instr_pc), 32'h1234);
    apply_stimulus(1'b0, 16'h0, 1'b1);
    check_output("jmp_n3_pc", 32'(instr_pc), 32'h1235);

    // Address wrap.
    apply_stimulus(1'b1, 16'hFFFF, 1'b1);
    apply_stimulus(1'b0, 16'h0, 1'b1);
    check_output("wrap_pc0", 32'(instr_pc), 32'hFFFF);
    apply_stimulus(1'b0, 16'h0, 1'b1);
    check_output("wrap_pc1", 32'(instr_pc), 32'h0000);

    // Back-to-back jumps; only the last target should appear.
    apply_stimulus(1'b1, 16'h0100, 1'b1);
    apply_stimulus(1'b1, 16'h0200, 1'b1);
    apply_stimulus(1'b1, 16'h0300, 1'b1);
    repeat (4) apply_stimulus(1'b0, 16'h0, 1'b1);

    // Reset mid-stream.
    repeat (3) apply_stimulus(1'b0, 16'h0, 1'b0);
    pulse_reset();
    apply_stimulus(1'b0, 16'h0, 1'b0);
    check_output("rst_restart_pc", 32'(instr_pc), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r == 0) begin
        pulse_reset();
      end else begin
        logic [15:0] ja;
        ja = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
        apply_stimulus(r < 8, ja, $urandom_range(0, 2) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
